muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for MIPS32 MULT/MULTU/DIV/DIVU (funct 24/25/26/27) and the HI/LO pair.

---
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// One shared datapath runs shift-add multiply or restoring divide on operand magnitudes.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funCode,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, zdiv_q, zdiv_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

    logic             fn_valid, fn_signed, fn_div, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign fn_valid  = (funCode >= 6'd24) && (funCode <= 6'd27);
    assign fn_signed = ~funCode[0];
    assign fn_div    = funCode[1];
    assign rs_neg    = fn_signed & rs_val[WIDTH-1];
    assign rt_neg    = fn_signed & rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    // acc holds the running high product / partial remainder, mq the multiplier / quotient.
    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shl  = {acc_q, mq_q[WIDTH-1]};
    assign div_diff = div_shl - {1'b0, opnd_q};
    assign prod_neg = -{acc_q, mq_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        zdiv_d     = zdiv_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        busy_d     = (state_q == StCalc) || (state_q == StFix);
        done_d     = 1'b0;

        if (!busy_q) begin
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
        end

        unique case (state_q)
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = div_diff[WIDTH-1:0];
                            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = div_shl[WIDTH-1:0];
                            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_d = StFix;
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        if (neg_q) mq_d = -mq_q;
                        if (rem_neg_q) acc_d = -acc_q;
                    end else if (neg_q) begin
                        {acc_d, mq_d} = prod_neg;
                    end
                    state_d = StDone;
                end
            end
            StIdle, StDone: begin
                // The commit outranks a same-edge MTHI/MTLO; a flush here cancels a pending commit.
                if (state_q == StDone && !flush) begin
                    hi_d       = acc_q;
                    lo_d       = mq_q;
                    done_d     = 1'b1;
                    div_zero_d = zdiv_q;
                end
                state_d = StIdle;
                if (start && fn_valid && !flush) begin
                    cnt_d      = '0;
                    is_div_d   = fn_div;
                    neg_d      = rs_neg ^ rt_neg;
                    rem_neg_d  = rs_neg;
                    div_zero_d = 1'b0;
                    if (fn_div && rt_val == '0) begin
                        zdiv_d  = 1'b1;
                        acc_d   = rs_val;
                        mq_d    = '1;
                        state_d = StDone;
                    end else begin
                        zdiv_d  = 1'b0;
                        acc_d   = '0;
                        mq_d    = fn_div ? rs_mag : rt_mag;
                        opnd_d  = fn_div ? rt_mag : rs_mag;
                        state_d = StCalc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            zdiv_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            zdiv_q     <= zdiv_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against an arithmetic model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, wr_hi, wr_lo;
    logic [5:0]  fun_code;
    logic [31:0] rs, rt, wr_data, hi, lo;
    logic        busy, done, div_zero;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funCode(fun_code),
        .rs_val(rs), .rt_val(rt), .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] fn, input logic [31:0] a, b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            6'd24: return 64'(sa * sb);
            6'd25: return {32'd0, a} * {32'd0, b};
            6'd26: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Caller must be at a negedge; returns edges from acceptance to visible done, busy cycle count.
    task automatic run_here(input logic [5:0] fn, input logic [31:0] a, b,
                            output int lat, output int bcnt);
        start = 1'b1; fun_code = fn; rs = a; rt = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [5:0] fn, input logic [31:0] a, b,
                         output int lat, output int bcnt);
        @(negedge clk);
        run_here(fn, a, b, lat, bcnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        fun_code = '0; rs = '0; rt = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int lat, bcnt;
        do_op(6'd24, 32'hFFFF_FFFE, 32'd3, lat, bcnt);
        total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        total++; if (bcnt !== 33) begin bad++; $display("FAIL mult_busy got=%0d exp=33", bcnt); end
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            bad++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffffa", hi, lo); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mult_after got busy=%b done=%b exp 0 0", busy, done); end
        do_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            bad++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
        do_op(6'd26, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
        do_op(6'd27, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        total++; if ({hi, lo} !== 64'h0000_0001_7FFF_FFFC) begin
            bad++; $display("FAIL divu got=%h_%h exp=00000001_7ffffffc", hi, lo); end
        do_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            bad++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo); end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h2222_2222;
        run_here(6'd26, 32'h0000_1234, 32'd0, lat, bcnt);
        wr_lo = 1'b0;
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        total++; if (bcnt !== 0) begin bad++; $display("FAIL dz_busy got=%0d exp=0", bcnt); end
        total++; if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) begin
            bad++; $display("FAIL dz_result got=%h_%h exp=00001234_ffffffff", hi, lo); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        repeat (3) @(negedge clk);
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_hold got=%b exp=1", div_zero); end
        start = 1'b1; fun_code = 6'd25; rs = 32'd5; rt = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_flush;
        logic seen;
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5555_AAAA;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        total++; if ({hi, lo} !== {2{32'h5555_AAAA}}) begin
            bad++; $display("FAIL mt_both got=%h_%h exp=5555aaaa_5555aaaa", hi, lo); end
        start = 1'b1; fun_code = 6'd24; rs = 32'd7; rt = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_prebusy got=%b exp=1", busy); end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_nodone got=%b exp=0", seen); end
        total++; if ({hi, lo} !== {2{32'h5555_AAAA}}) begin
            bad++; $display("FAIL flush_keep got=%h_%h exp=5555aaaa_5555aaaa", hi, lo); end
    endtask

    task automatic test_ignored_start;
        int lat, dones;
        logic [63:0] exp;
        exp = ref_result(6'd25, 32'hDEAD_BEEF, 32'h0001_0003);
        @(negedge clk);
        start = 1'b1; fun_code = 6'd25; rs = 32'hDEAD_BEEF; rt = 32'h0001_0003;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; dones = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin
                start = 1'b1; fun_code = 6'd27; rs = 32'd100; rt = 32'd7;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) lat = k;
            end
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL ign_latency got=%0d exp=34", lat); end
        total++; if (dones !== 1) begin bad++; $display("FAIL ign_dones got=%0d exp=1", dones); end
        total++; if ({hi, lo} !== exp) begin
            bad++; $display("FAIL ign_result got=%h_%h exp=%h", hi, lo, exp); end
    endtask

    task automatic test_back_to_back;
        int lat, lat1;
        logic [63:0] e1, e2;
        e1 = ref_result(6'd24, 32'h0000_1111, 32'hFFFF_FF00);
        e2 = ref_result(6'd27, 32'hF000_0001, 32'h0000_0013);
        do_op(6'd24, 32'h0000_1111, 32'hFFFF_FF00, lat1, lat);
        total++; if ({hi, lo} !== e1) begin
            bad++; $display("FAIL b2b_first got=%h_%h exp=%h", hi, lo, e1); end
        start = 1'b1; fun_code = 6'd27; rs = 32'hF000_0001; rt = 32'h0000_0013;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 3) begin wr_lo = 1'b1; wr_data = 32'h0000_ABCD; end
            @(posedge clk);
            @(negedge clk);
            wr_lo = 1'b0;
            if (k == 5) begin
                total++; if (lo !== e1[31:0]) begin
                    bad++; $display("FAIL busy_write got=%h exp=%h", lo, e1[31:0]); end
            end
            if (done) begin lat = k; break; end
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        total++; if ({hi, lo} !== e2) begin
            bad++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, e2); end
        // Write issued in the done cycle lands on the next edge.
        wr_hi = 1'b1; wr_data = 32'h0000_1357;
        @(negedge clk);
        wr_hi = 1'b0;
        total++; if ({hi, lo} !== {32'h0000_1357, e2[31:0]}) begin
            bad++; $display("FAIL done_write got=%h_%h exp=00001357_%h", hi, lo, e2[31:0]); end
        wr_lo = 1'b1; wr_data = 32'h0000_ABCD;
        @(negedge clk);
        wr_lo = 1'b0;
        total++; if ({hi, lo} !== {32'h0000_1357, 32'h0000_ABCD}) begin
            bad++; $display("FAIL idle_write got=%h_%h exp=00001357_0000abcd", hi, lo); end
    endtask

    task automatic test_random;
        int lat, bcnt, exp_lat, exp_b;
        logic [5:0] fn;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            fn = 6'(24 + $urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            exp = ref_result(fn, a, b);
            exp_lat = (fn[1] && b == 0) ? 1 : 34;
            exp_b = (exp_lat == 1) ? 0 : 33;
            do_op(fn, a, b, lat, bcnt);
            total++; if (lat !== exp_lat || bcnt !== exp_b) begin
                bad++; $display("FAIL rand_timing fn=%0d got lat=%0d busy=%0d exp lat=%0d busy=%0d",
                                fn, lat, bcnt, exp_lat, exp_b); end
            total++; if ({hi, lo} !== exp || div_zero !== (exp_lat == 1)) begin
                bad++; $display("FAIL rand_result fn=%0d a=%h b=%h got=%h_%h dz=%b exp=%h",
                                fn, a, b, hi, lo, div_zero, exp); end
        end
    endtask

    task automatic test_mid_reset;
        logic seen;
        @(negedge clk);
        start = 1'b1; fun_code = 6'd26; rs = 32'd1000; rt = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if ({hi, lo, busy, done, div_zero} !== '0) begin
            bad++; $display("FAIL mid_reset got hi=%h lo=%h b=%b d=%b dz=%b exp all 0",
                            hi, lo, busy, done, div_zero); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_quiet got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_zero;
        test_flush;
        test_ignored_start;
        test_back_to_back;
        test_random;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
